// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper
// Packs a serial coded-bit stream into 1/2/3-bit symbols (BPSK/QPSK/8PSK),
// Gray-maps each symbol onto an 8-point phase grid, rotates it by the current
// 45-degree-step phase offset and emits signed I/Q samples.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_bits_per_sym        1/2/3 bits per symbol, latched while i_reset=1
//   i_angle_step          phase increment (45 deg units), latched while i_reset=1
//   i_rotate_period       symbols between rotations (auto mode)
//   i_shift_phase_stb     advance phase (manual mode)
//   i_sync                restart rotation symbol counter (auto mode)
//   o_last_phase_stb      registered pulse when the angle wraps to 0
//   i_bit/i_bit_valid/o_bit_ready   coded-bit input stream
//   o_data_i/o_data_q/o_valid/i_ready  signed I/Q output stream
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds its data stable while valid & ~ready; valid never
// depends combinationally on ready. o_bit_ready only drops on the last bit of
// a symbol when the output register is full and not being drained.
module psk_symbol_mapper #(
  parameter int IQ_WIDTH            = 10,
  parameter int ROTATE_PERIOD_WIDTH = 24,
  parameter int AUTO_PHASE_CTRL     = 0
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [2:0]                     i_bits_per_sym,
  input  logic [2:0]                     i_angle_step,
  input  logic [ROTATE_PERIOD_WIDTH-1:0] i_rotate_period,
  input  logic                           i_shift_phase_stb,
  input  logic                           i_sync,
  output logic                           o_last_phase_stb,
  input  logic                           i_bit,
  input  logic                           i_bit_valid,
  output logic                           o_bit_ready,
  output logic [IQ_WIDTH-1:0]            o_data_i,
  output logic [IQ_WIDTH-1:0]            o_data_q,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int A_INT = (1 << (IQ_WIDTH - 1)) - 1;
  // round(0.707 * A) in integer arithmetic
  localparam int B_INT = (A_INT * 707 + 500) / 1000;
  localparam logic [IQ_WIDTH-1:0] P_A  = IQ_WIDTH'(A_INT);
  localparam logic [IQ_WIDTH-1:0] N_A  = IQ_WIDTH'(-A_INT);
  localparam logic [IQ_WIDTH-1:0] P_B  = IQ_WIDTH'(B_INT);
  localparam logic [IQ_WIDTH-1:0] N_B  = IQ_WIDTH'(-B_INT);
  localparam logic [IQ_WIDTH-1:0] ZERO = '0;

  logic [1:0]                     r_cnt_last;  // N-1
  logic [2:0]                     r_step;
  logic [1:0]                     r_bit_cnt;
  logic [1:0]                     r_sym;
  logic [2:0]                     r_angle;
  logic [ROTATE_PERIOD_WIDTH-1:0] r_sym_cnt;
  logic                           r_last_phase_stb;
  logic                           r_valid;
  logic [IQ_WIDTH-1:0]            r_data_i;
  logic [IQ_WIDTH-1:0]            r_data_q;

  logic [1:0]          w_cnt_last_cfg;
  logic                w_last_bit;
  logic                w_accept;
  logic                w_complete;
  logic [2:0]          w_sym;
  logic [2:0]          w_p;
  logic [2:0]          w_k;
  logic [IQ_WIDTH-1:0] w_i;
  logic [IQ_WIDTH-1:0] w_q;
  logic [2:0]          w_angle_sum;
  logic                w_auto_tick;
  logic                w_next_phase;

  // Unsupported bits-per-symbol settings fall back to BPSK.
  always_comb begin
    w_cnt_last_cfg = 2'd0;
    case (i_bits_per_sym)
      3'd2:    w_cnt_last_cfg = 2'd1;
      3'd3:    w_cnt_last_cfg = 2'd2;
      default: w_cnt_last_cfg = 2'd0;
    endcase
  end

  assign w_last_bit  = (r_bit_cnt == r_cnt_last);
  assign o_bit_ready = ~w_last_bit | ~r_valid | i_ready;
  assign w_accept    = i_bit_valid & o_bit_ready;
  assign w_complete  = w_accept & w_last_bit;

  // Earlier bits sit in r_sym (oldest highest), current bit is the LSB.
  assign w_sym = {r_sym, i_bit};

  always_comb begin
    w_p = 3'd0;
    case (r_cnt_last)
      2'd1: begin
        case (w_sym[1:0])
          2'b00:   w_p = 3'd1;
          2'b10:   w_p = 3'd3;
          2'b11:   w_p = 3'd5;
          default: w_p = 3'd7;
        endcase
      end
      2'd2: begin
        case (w_sym)
          3'b000:  w_p = 3'd0;
          3'b001:  w_p = 3'd1;
          3'b011:  w_p = 3'd2;
          3'b010:  w_p = 3'd3;
          3'b110:  w_p = 3'd4;
          3'b111:  w_p = 3'd5;
          3'b101:  w_p = 3'd6;
          default: w_p = 3'd7;
        endcase
      end
      default: w_p = w_sym[0] ? 3'd4 : 3'd0;
    endcase
  end

  // Rotation uses the angle before any same-cycle update.
  assign w_k = w_p + r_angle;

  always_comb begin
    w_i = ZERO;
    w_q = ZERO;
    case (w_k)
      3'd0: begin w_i = P_A;  w_q = ZERO; end
      3'd1: begin w_i = P_B;  w_q = P_B;  end
      3'd2: begin w_i = ZERO; w_q = P_A;  end
      3'd3: begin w_i = N_B;  w_q = P_B;  end
      3'd4: begin w_i = N_A;  w_q = ZERO; end
      3'd5: begin w_i = N_B;  w_q = N_B;  end
      3'd6: begin w_i = ZERO; w_q = N_A;  end
      default: begin w_i = P_B; w_q = N_B; end
    endcase
  end

  // i_sync takes priority over the period tick.
  assign w_auto_tick  = w_complete & ~i_sync & (r_sym_cnt == i_rotate_period);
  assign w_next_phase = (AUTO_PHASE_CTRL != 0) ? w_auto_tick : i_shift_phase_stb;
  assign w_angle_sum  = r_angle + r_step;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt_last       <= w_cnt_last_cfg;
      r_step           <= i_angle_step;
      r_bit_cnt        <= 2'd0;
      r_sym            <= 2'd0;
      r_angle          <= 3'd0;
      r_sym_cnt        <= '0;
      r_last_phase_stb <= 1'b0;
      r_valid          <= 1'b0;
      r_data_i         <= '0;
      r_data_q         <= '0;
    end else begin
      if (w_accept) begin
        r_sym     <= {r_sym[0], i_bit};
        r_bit_cnt <= w_last_bit ? 2'd0 : r_bit_cnt + 2'd1;
      end

      if (w_complete) begin
        r_valid  <= 1'b1;
        r_data_i <= w_i;
        r_data_q <= w_q;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_next_phase) begin
        r_angle <= w_angle_sum;
      end
      r_last_phase_stb <= w_next_phase & (w_angle_sum == 3'd0);

      if (i_sync || w_auto_tick) begin
        r_sym_cnt <= '0;
      end else if (w_complete) begin
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end
    end
  end

  assign o_valid          = r_valid;
  assign o_data_i         = r_data_i;
  assign o_data_q         = r_data_q;
  assign o_last_phase_stb = r_last_phase_stb;

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Testbench for psk_symbol_mapper: one manual-phase and one auto-phase
// instance sharing stimulus; table-driven mapping vectors plus hand-written
// sequences for strobes, backpressure, auto rotation and reset.
module tb_psk_symbol_mapper;
  localparam int W = 10;
  localparam int RPW = 24;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [2:0]     i_bits_per_sym;
  logic [2:0]     i_angle_step;
  logic [RPW-1:0] i_rotate_period;
  logic           i_shift_phase_stb;
  logic           i_sync;
  logic           i_bit;
  logic           i_bit_valid;
  logic           i_ready;

  logic           m_last, m_bit_ready, m_valid;
  logic [W-1:0]   m_i, m_q;
  logic           a_last, a_bit_ready, a_valid;
  logic [W-1:0]   a_i, a_q;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  psk_symbol_mapper #(.IQ_WIDTH(W), .ROTATE_PERIOD_WIDTH(RPW), .AUTO_PHASE_CTRL(0)) u_man (
    .i_clk(i_clk), .i_reset(i_reset), .i_bits_per_sym(i_bits_per_sym),
    .i_angle_step(i_angle_step), .i_rotate_period(i_rotate_period),
    .i_shift_phase_stb(i_shift_phase_stb), .i_sync(i_sync),
    .o_last_phase_stb(m_last), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(m_bit_ready), .o_data_i(m_i), .o_data_q(m_q),
    .o_valid(m_valid), .i_ready(i_ready)
  );

  psk_symbol_mapper #(.IQ_WIDTH(W), .ROTATE_PERIOD_WIDTH(RPW), .AUTO_PHASE_CTRL(1)) u_auto (
    .i_clk(i_clk), .i_reset(i_reset), .i_bits_per_sym(i_bits_per_sym),
    .i_angle_step(i_angle_step), .i_rotate_period(i_rotate_period),
    .i_shift_phase_stb(i_shift_phase_stb), .i_sync(i_sync),
    .o_last_phase_stb(a_last), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_bit_ready(a_bit_ready), .o_data_i(a_i), .o_data_q(a_q),
    .o_valid(a_valid), .i_ready(i_ready)
  );

  typedef struct {
    int          n;
    int          step;
    int          strobes;
    int          nbits;
    logic [2:0]  bits;   // sent MSB first, nbits of them
    int          ei;
    int          eq;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int n, input int step);
    i_reset           = 1'b1;
    i_bits_per_sym    = 3'(n);
    i_angle_step      = 3'(step);
    i_bit_valid       = 1'b0;
    i_bit             = 1'b0;
    i_shift_phase_stb = 1'b0;
    i_sync            = 1'b0;
    i_ready           = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic strobe();
    i_shift_phase_stb = 1'b1;
    tick();
    i_shift_phase_stb = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    i_bit       = b;
    i_bit_valid = 1'b1;
    tick();
    i_bit_valid = 1'b0;
  endtask

  task automatic check_auto_sym(input string name, input int angle);
    int ei, eq;
    ei = (angle == 0) ? 511 : (angle == 4) ? -511 : 0;
    eq = (angle == 2) ? 511 : (angle == 6) ? -511 : 0;
    send_bit(1'b0);
    check({name, "_valid"}, int'(a_valid), 1);
    check({name, "_i"}, $signed(a_i), ei);
    check({name, "_q"}, $signed(a_q), eq);
  endtask

  initial begin
    i_rotate_period = RPW'(3);
    do_reset(1, 0);

    // Reset state
    check("rst_valid", int'(m_valid), 0);
    check("rst_i", $signed(m_i), 0);
    check("rst_q", $signed(m_q), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_ready", int'(m_bit_ready), 1);

    //          n  step strb nb bits     I     Q
    vecs[0]  = '{1, 0, 0, 1, 3'b000,  511,    0};
    vecs[1]  = '{1, 0, 0, 1, 3'b001, -511,    0};
    vecs[2]  = '{2, 0, 0, 2, 3'b010, -361,  361};
    vecs[3]  = '{2, 0, 0, 2, 3'b001,  361, -361};
    vecs[4]  = '{3, 1, 1, 3, 3'b011, -361,  361};
    vecs[5]  = '{3, 0, 0, 3, 3'b100,  361, -361};
    vecs[6]  = '{3, 3, 2, 3, 3'b110,    0,  511};
    vecs[7]  = '{0, 0, 0, 1, 3'b001, -511,    0};
    vecs[8]  = '{7, 2, 1, 1, 3'b000,    0,  511};
    vecs[9]  = '{2, 4, 1, 2, 3'b011,  361,  361};
    vecs[10] = '{3, 0, 0, 3, 3'b101,    0, -511};

    for (int v = 0; v < 11; v++) begin
      do_reset(vecs[v].n, vecs[v].step);
      for (int s = 0; s < vecs[v].strobes; s++) strobe();
      for (int b = vecs[v].nbits - 1; b >= 0; b--) begin
        check($sformatf("v%0d_rdy", v), int'(m_bit_ready), 1);
        send_bit(vecs[v].bits[b]);
        if (b != 0) check($sformatf("v%0d_early_valid", v), int'(m_valid), 0);
      end
      check($sformatf("v%0d_valid", v), int'(m_valid), 1);
      check($sformatf("v%0d_i", v), $signed(m_i), vecs[v].ei);
      check($sformatf("v%0d_q", v), $signed(m_q), vecs[v].eq);
      if (vecs[v].step == 0) check($sformatf("v%0d_last", v), int'(m_last), 0);
      tick();
      check($sformatf("v%0d_drain", v), int'(m_valid), 0);
    end

    // Eight strobes with step 1: exactly one wrap pulse, after the 8th
    do_reset(3, 1);
    for (int s = 1; s <= 8; s++) begin
      strobe();
      check($sformatf("wrap_s%0d", s), int'(m_last), (s == 8) ? 1 : 0);
    end
    tick();
    check("wrap_after", int'(m_last), 0);

    // step 0: every strobe wraps
    do_reset(1, 0);
    strobe();
    check("step0_last", int'(m_last), 1);
    tick();
    check("step0_last_clr", int'(m_last), 0);

    // Back-to-back BPSK at full rate
    do_reset(1, 0);
    i_bit_valid = 1'b1;
    i_bit = 1'b0; tick();
    check("b2b0_i", $signed(m_i), 511);
    i_bit = 1'b1; tick();
    check("b2b1_valid", int'(m_valid), 1);
    check("b2b1_i", $signed(m_i), -511);
    check("b2b1_rdy", int'(m_bit_ready), 1);
    i_bit = 1'b0; tick();
    check("b2b2_i", $signed(m_i), 511);
    i_bit_valid = 1'b0;
    tick();

    // Backpressure, QPSK
    do_reset(2, 0);
    i_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("bp_valid", int'(m_valid), 1);
    check("bp_i", $signed(m_i), -361);
    check("bp_q", $signed(m_q), -361);
    i_bit = 1'b0; i_bit_valid = 1'b1;
    check("bp_rdy_first", int'(m_bit_ready), 1);
    tick();
    check("bp_rdy_second", int'(m_bit_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_hold_v%0d", c), int'(m_valid), 1);
      check($sformatf("bp_hold_i%0d", c), $signed(m_i), -361);
      check($sformatf("bp_hold_q%0d", c), $signed(m_q), -361);
      check($sformatf("bp_hold_r%0d", c), int'(m_bit_ready), 0);
    end
    i_ready = 1'b1;
    #1;
    check("bp_rdy_release", int'(m_bit_ready), 1);
    tick();
    i_bit_valid = 1'b0;
    check("bp_new_valid", int'(m_valid), 1);
    check("bp_new_i", $signed(m_i), 361);
    check("bp_new_q", $signed(m_q), 361);
    tick();
    check("bp_drain", int'(m_valid), 0);

    // Auto phase: period 3, step 2 -> angle changes every 4 symbols
    do_reset(1, 2);
    for (int s = 0; s < 9; s++) check_auto_sym($sformatf("auto%0d", s), (s / 4) * 2);

    // i_sync after two symbols restarts the 4-symbol count
    do_reset(1, 2);
    check_auto_sym("sync_pre0", 0);
    check_auto_sym("sync_pre1", 0);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    for (int s = 0; s < 5; s++) check_auto_sym($sformatf("sync_post%0d", s), (s == 4) ? 2 : 0);

    // Reset mid-symbol drops partial bits
    do_reset(3, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    do_reset(3, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("mid_rst_none", int'(m_valid), 0);
    send_bit(1'b0);
    check("mid_rst_valid", int'(m_valid), 1);
    check("mid_rst_i", $signed(m_i), 511);
    check("mid_rst_q", $signed(m_q), 0);
    tick();
    check("mid_rst_single", int'(m_valid), 0);

    // Reset while an output is pending
    i_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("rst_pend_valid", int'(m_valid), 1);
    do_reset(3, 0);
    check("rst_pend_drop", int'(m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psk_symbol_mapper.md
Name: psk_symbol_mapper

Overview:
- Transmit-side counterpart of the LLR former.
- Accepts a serial coded-bit stream and packs 1/2/3 bits per symbol (BPSK/QPSK/8PSK).
- Gray-maps each symbol onto an 8-point phase grid, applies the same 45°-step phase rotation schedule the receiver undoes, and outputs signed I/Q samples with valid/ready handshake.
- Sits between the convolutional encoder and the DAC/test-loopback path.

Parameters:
- IQ_WIDTH, 10, signed I/Q output width.
- ROTATE_PERIOD_WIDTH, 24, width of i_rotate_period.
- AUTO_PHASE_CTRL, 0, 1 = rotation advanced by internal symbol counter; 0 = by i_shift_phase_stb.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_bits_per_sym  in  3  1=BPSK, 2=QPSK, 3=8PSK; latched while i_reset=1
- i_angle_step  in  3  phase increment in 45° units; latched while i_reset=1
- i_rotate_period  in  ROTATE_PERIOD_WIDTH  symbols between rotations (auto mode)
- i_shift_phase_stb  in  1  advance phase (manual mode)
- i_sync  in  1  restart rotation counter (auto mode)
- o_last_phase_stb  out  1  pulse when the angle wraps to 0
- i_bit  in  1  coded bit
- i_bit_valid  in  1  bit qualifier
- o_bit_ready  out  1  bit accepted when i_bit_valid & o_bit_ready
- o_data_i  out  IQ_WIDTH  signed I
- o_data_q  out  IQ_WIDTH  signed Q
- o_valid  out  1  I/Q valid
- i_ready  in  1  downstream accepts I/Q

Behaviour:
- Config: N = latched i_bits_per_sym. Values 0 and 4..7 are treated as 1.
- Reset state: o_valid=0, o_data_i=o_data_q=0, bit_cnt=0, partial bits discarded, angle_reg=0, rotation counter=0, o_last_phase_stb=0.
- Bit packing:
  - Accepted bits shift into sym_reg; the first bit received is the MSB.
  - bit_cnt counts 0..N-1.
  - The accept with bit_cnt=N-1 completes the symbol and resets bit_cnt to 0.
- Ready rule: o_bit_ready = (bit_cnt != N-1) | ~o_valid | i_ready. Partial bits are never stalled.
- Gray map to base phase index p (units of 45°):
  - BPSK: 0→0, 1→4.
  - QPSK: 00→1, 10→3, 11→5, 01→7.
  - 8PSK: 000→0, 001→1, 011→2, 010→3, 110→4, 111→5, 101→6, 100→7.
- Rotation: k = (p + angle_reg) mod 8, where angle_reg is sampled at the completing-accept edge (pre-update value if the angle advances in the same cycle).
- Output LUT:
  - A = 2^(IQ_WIDTH-1)-1; B = round(0.707*A). For IQ_WIDTH=10, A=511 and B=361.
  - (I,Q) by k: 0:(A,0), 1:(B,B), 2:(0,A), 3:(-B,B), 4:(-A,0), 5:(-B,-B), 6:(0,-A), 7:(B,-B).
- Output register:
  - Loaded on the completing-accept edge, so o_valid rises the cycle after the last bit.
  - Held stable while o_valid & ~i_ready.
  - Cleared (o_valid=0) after a handshake with no new symbol in the same cycle.
  - Back-to-back symbols at full rate are allowed when N=1 and i_ready=1.
- Phase control:
  - next_phase = i_shift_phase_stb (manual) or auto_tick (auto).
  - On next_phase: angle_reg <= angle_reg + step (mod 8).
  - o_last_phase_stb = registered (next_phase & ((angle_reg+step) mod 8 == 0)).
  - step=0 with next_phase asserts o_last_phase_stb every strobe.
- Auto mode:
  - sym_cnt increments on each completed symbol when i_sync=0.
  - sym_cnt is cleared by i_reset, i_sync, or auto_tick.
  - auto_tick = (sym_cnt == i_rotate_period) & symbol completion.
  - i_sync overrides increment and tick in the same cycle.
- Reset mid-symbol or mid-handshake: reset wins; the pending output is dropped.

Test Plan:
- Basic mapping: IQ_WIDTH=10, N=1, step=0, bits 0,1 → (511,0), (-511,0); o_valid 1 cycle after each accept; o_last_phase_stb never asserts.
- QPSK Gray: N=2, bits 1,0 then 0,1 → (-361,361), (361,-361); o_bit_ready stays 1 throughout.
- 8PSK rotation: N=3, step=1, strobe once, then bits 0,1,1 → k=3 → (-361,361). Eight strobes total → exactly one o_last_phase_stb, on the 8th strobe's following cycle.
- Backpressure: N=2, hold i_ready=0 with o_valid=1 → o_bit_ready=1 on first bit, 0 on second; outputs frozen; i_ready=1 → symbol consumed next edge, second bit accepted.
- Auto phase: AUTO_PHASE_CTRL=1, period=3, step=2, N=1 → angle 0,0,0,0,2,2,2,2,4... per symbol; i_sync pulse after symbol 2 restarts the 4-symbol count.
- Reset mid-symbol: N=3, send 2 bits, pulse i_reset, send 0,0,0 → single output (511,0); no stale bits emitted.
